// File: rtl/coeff_pkg.sv
// Shared constants and FSM state encoding for the FIR coefficient loader.
// The defaults describe a 72-tap bank with 16-bit signed coefficients.
package coeff_pkg;

  localparam int N_COEFF = 72;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 16;
  localparam int SUM_W   = 23;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    MIRROR = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/coeff_loader_if.sv
// Valid/ready coefficient stream feeding the loader.
// The producer uses the master modport and the loader uses the slave modport.
interface coeff_loader_if #(
  parameter int DATA_W = coeff_pkg::DATA_W
);

  logic                     s_valid;
  logic                     s_ready;
  logic signed [DATA_W-1:0] s_data;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );

endinterface

// File: rtl/coeff_loader.sv
// Write-side sequencer for the FIR coefficient RAM: full or mirrored loads,
// running signed sum of written words and a one-cycle completion pulse.
module coeff_loader #(
  parameter int N_COEFF = coeff_pkg::N_COEFF,
  parameter int ADDR_W  = coeff_pkg::ADDR_W,
  parameter int DATA_W  = coeff_pkg::DATA_W,
  parameter int SUM_W   = DATA_W + ADDR_W
) (
  input  logic                     clk_r,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     sym,
  input  logic                     abort,
  coeff_loader_if.slave            strm,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        addr_in,
  output logic signed [DATA_W-1:0] wr_data,
  output logic                     busy,
  output logic                     done,
  output logic signed [SUM_W-1:0]  coeff_sum
);

  import coeff_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_COEFF - 1);
  localparam logic [ADDR_W-1:0] HALF_IDX = ADDR_W'(N_COEFF / 2 - 1);

  state_e                    state_r;
  logic                      sym_q_r;
  logic [ADDR_W-1:0]         idx_r;
  logic signed [SUM_W-1:0]   sum_r;
  logic                      wr_en_r;
  logic [ADDR_W-1:0]         addr_r;
  logic signed [DATA_W-1:0]  wr_data_r;
  logic                      busy_r;
  logic                      done_r;
  logic                      s_ready_r;
  logic                      xfer_s;

  function automatic logic signed [SUM_W-1:0] sext(input logic signed [DATA_W-1:0] d);
    return {{(SUM_W - DATA_W){d[DATA_W-1]}}, d};
  endfunction

  // s_ready_r is only high in LOAD, so this is the accepted-word strobe.
  assign xfer_s = strm.s_valid && s_ready_r;

  // Load sequencer: state, index, running sum and all registered outputs.
  always_ff @(posedge clk_r) begin
    if (rst) begin
      state_r   <= IDLE;
      sym_q_r   <= 1'b0;
      idx_r     <= {ADDR_W{1'b0}};
      sum_r     <= {SUM_W{1'b0}};
      wr_en_r   <= 1'b0;
      addr_r    <= {ADDR_W{1'b0}};
      wr_data_r <= {DATA_W{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      s_ready_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          wr_en_r <= 1'b0;
          done_r  <= 1'b0;
          if (start) begin
            sym_q_r   <= sym;
            idx_r     <= {ADDR_W{1'b0}};
            sum_r     <= {SUM_W{1'b0}};
            state_r   <= LOAD;
            s_ready_r <= 1'b1;
            busy_r    <= 1'b1;
          end else begin
            s_ready_r <= 1'b0;
            busy_r    <= 1'b0;
          end
        end

        LOAD: begin
          done_r <= 1'b0;
          if (abort) begin
            // Abort wins over a word presented in the same cycle.
            state_r   <= IDLE;
            wr_en_r   <= 1'b0;
            s_ready_r <= 1'b0;
            busy_r    <= 1'b0;
          end else if (xfer_s) begin
            wr_en_r   <= 1'b1;
            addr_r    <= idx_r;
            wr_data_r <= strm.s_data;
            sum_r     <= sum_r + sext(strm.s_data);
            if (sym_q_r) begin
              state_r   <= MIRROR;
              s_ready_r <= 1'b0;
            end else begin
              idx_r <= idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
              if (idx_r == LAST_IDX) begin
                state_r   <= DONE;
                s_ready_r <= 1'b0;
                busy_r    <= 1'b0;
              end else begin
                state_r <= LOAD;
              end
            end
          end else begin
            wr_en_r <= 1'b0;
          end
        end

        MIRROR: begin
          done_r <= 1'b0;
          if (abort) begin
            state_r   <= IDLE;
            wr_en_r   <= 1'b0;
            s_ready_r <= 1'b0;
            busy_r    <= 1'b0;
          end else begin
            // Re-write the word just accepted at the mirrored address.
            wr_en_r <= 1'b1;
            addr_r  <= LAST_IDX - idx_r;
            sum_r   <= sum_r + sext(wr_data_r);
            idx_r   <= idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            if (idx_r == HALF_IDX) begin
              state_r   <= DONE;
              s_ready_r <= 1'b0;
              busy_r    <= 1'b0;
            end else begin
              state_r   <= LOAD;
              s_ready_r <= 1'b1;
            end
          end
        end

        DONE: begin
          // The final write is visible during DONE; the pulse follows it.
          state_r   <= IDLE;
          wr_en_r   <= 1'b0;
          done_r    <= 1'b1;
          s_ready_r <= 1'b0;
          busy_r    <= 1'b0;
        end

        default: begin
          state_r   <= IDLE;
          wr_en_r   <= 1'b0;
          done_r    <= 1'b0;
          s_ready_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign strm.s_ready = s_ready_r;
  assign wr_en        = wr_en_r;
  assign addr_in      = addr_r;
  assign wr_data      = wr_data_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign coeff_sum    = sum_r;

endmodule
